data_capture: RTL and testbench

//  Capture-side counterpart of the GPIO sample-injection path: records ADC-width samples from the

---
 rtl/data_capture_pkg.sv | 31 +++
 rtl/data_capture_if.sv | 43 ++++
 rtl/data_capture_ram.sv | 37 +++
 rtl/data_capture.sv | 166 ++++++++++++++++
 tb/tb_data_capture.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_capture_pkg.sv
// rtl/data_capture_pkg.sv - shared FSM encoding and GPIO bit-field map for data_capture
//
// Purpose: the capture FSM state type and the GPIO control/status field positions.
//          The field positions are also mirrored in the PS software headers.
// Ports:   none (package)
package data_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // gpio_ctrl fields
    localparam int RD_ADDR_LSB  = 0;
    localparam int RD_ADDR_MSB  = 13;
    localparam int ARM_BIT      = 14;

    // gpio_status fields
    localparam int STAT_RD_LSB  = 0;
    localparam int STAT_DONE    = 14;
    localparam int STAT_BUSY    = 15;
    localparam int STAT_CNT_LSB = 16;
    localparam int STAT_ARMED   = 31;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/data_capture_if.sv
// rtl/data_capture_if.sv - GPIO pair and ADC sample bus of data_capture
//
// Purpose: groups the PS GPIO control/status pair and the ADC sample stream.
// Ports (signals):
//   gpio_ctrl      PS -> capture  [13:0] read address, [14] arm
//   gpio_status    capture -> PS  [13:0] read data, [14] done, [15] busy,
//                                 [30:16] sample count, [31] armed
//   adc_data       sample to capture
//   adc_valid      adc_data qualifier, one sample per high cycle
//   trigger        capture start level (used only with CAPTURE_TRIG_EN)
//   capture_active high while capturing
// Modports: master = PS/datapath side, slave = capture block.
interface data_capture_if #(
    parameter int ADC_WIDTH  = 14,
    parameter int GPIO_WIDTH = 32
) ();

    logic [GPIO_WIDTH-1:0] gpio_ctrl;
    logic [GPIO_WIDTH-1:0] gpio_status;
    logic [ADC_WIDTH-1:0]  adc_data;
    logic                  adc_valid;
    logic                  trigger;
    logic                  capture_active;

    modport master (
        output gpio_ctrl,
        output adc_data,
        output adc_valid,
        output trigger,
        input  gpio_status,
        input  capture_active
    );

    modport slave (
        input  gpio_ctrl,
        input  adc_data,
        input  adc_valid,
        input  trigger,
        output gpio_status,
        output capture_active
    );

endinterface

// File: rtl/data_capture_ram.sv
// rtl/data_capture_ram.sv - simple dual-port sample RAM, read-first, registered read
//
// Purpose: 1 write port + 1 registered read port. A read of the address being
//          written in the same cycle returns the old contents (read-first).
//          Contents are never cleared; no reset so it maps onto block RAM.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, one cycle after i_raddr
module capture_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_capture.sv
// rtl/data_capture.sv - single-shot ADC sample capture into RAM with GPIO read-back
//
// Purpose: records CAPTURE_LEN samples from the ADC datapath into on-chip RAM
//          after an arm rising edge, then lets the PS read any word back over
//          the GPIO pair. Read-back is non-destructive and random-access.
// Build option: define CAPTURE_TRIG_EN to hold ARMED until trigger=1;
//          without it capture begins the cycle after ARMED is entered.
// Ports:
//   clk   clock, all logic on posedge
//   rst   asynchronous active-high reset
//   bus   data_capture_if.slave (gpio_ctrl, gpio_status, adc_data,
//         adc_valid, trigger, capture_active)
module data_capture
    import data_capture_pkg::*;
#(
    parameter int ADC_WIDTH   = 14,
    parameter int GPIO_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 14,
    parameter int CAPTURE_LEN = 16384
) (
    input  logic          clk,
    input  logic          rst,
    data_capture_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] LEN_C = (ADDR_WIDTH+1)'(CAPTURE_LEN);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_arm_d;
    logic                    r_arm_low_seen;
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [GPIO_WIDTH-1:0]   r_status;
    logic [GPIO_WIDTH-1:0]   w_status_next;
    logic                    w_arm;
    logic                    w_arm_rise;
    logic                    w_start;
    logic                    w_write;
    logic                    w_arm_entry;
    logic [ADDR_WIDTH-1:0]   w_raddr;
    logic [ADC_WIDTH-1:0]    w_rdata;
    logic                    w_unused;

    assign w_arm   = bus.gpio_ctrl[ARM_BIT];
    assign w_raddr = bus.gpio_ctrl[RD_ADDR_LSB +: ADDR_WIDTH];

`ifdef CAPTURE_TRIG_EN
    assign w_start  = bus.trigger;
    assign w_unused = ^bus.gpio_ctrl[GPIO_WIDTH-1:ARM_BIT+1];
`else
    assign w_start  = 1'b1;
    assign w_unused = ^{bus.gpio_ctrl[GPIO_WIDTH-1:ARM_BIT+1], bus.trigger};
`endif

    // arm_d resets low, so an arm held high through reset would look like a
    // fresh rising edge on release. r_arm_low_seen demands that arm is seen
    // low at least once after reset before any edge counts.
    assign w_arm_rise = w_arm && !r_arm_d && r_arm_low_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_d        <= 1'b0;
            r_arm_low_seen <= 1'b0;
        end else begin
            r_arm_d        <= w_arm;
            r_arm_low_seen <= r_arm_low_seen || !w_arm;
        end
    end

    // Samples are written on every adc_valid cycle spent in CAPTURE,
    // including the cycle arm drops (the FSM leaves on the following edge).
    assign w_write = (r_state == ST_CAPTURE) && bus.adc_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm_rise) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_start) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_write && (r_count == LEN_C - 1'b1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Dropping arm aborts from any state; partial data and count remain.
        if (!w_arm) begin
            w_state_next = ST_IDLE;
        end
    end

    // Pointer and count are cleared as ARMED is entered; nothing moves them
    // while ARMED, so they are still zero when CAPTURE begins and software
    // sees count=0 while waiting on a trigger.
    assign w_arm_entry = (r_state == ST_IDLE) && (w_state_next == ST_ARMED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_arm_entry) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_count < LEN_C) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    capture_ram #(
        .DATA_WIDTH(ADC_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_write),
        .i_waddr (r_wptr),
        .i_wdata (bus.adc_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_status_next                                = '0;
        w_status_next[STAT_RD_LSB +: ADC_WIDTH]      = w_rdata;
        w_status_next[STAT_DONE]                     = (r_state == ST_DONE);
        w_status_next[STAT_BUSY]                     = state_is_busy(r_state);
        w_status_next[STAT_CNT_LSB +: ADDR_WIDTH+1]  = r_count;
        w_status_next[STAT_ARMED]                    = (r_state == ST_ARMED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status <= w_status_next;
        end
    end

    assign bus.gpio_status    = r_status;
    assign bus.capture_active = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_data_capture.sv
// tb/tb_data_capture.sv - self-checking bench for data_capture with a behavioural model
module tb_data_capture;

    localparam int DEPTH = 1 << 14;
    localparam int LEN   = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    data_capture_if #(.ADC_WIDTH(14), .GPIO_WIDTH(32)) bif ();

    data_capture #(
        .ADC_WIDTH  (14),
        .GPIO_WIDTH (32),
        .ADDR_WIDTH (14),
        .CAPTURE_LEN(LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for start, 2 capturing, 3 done.
    int          m_phase;
    int          m_cnt;
    int          m_wp;
    bit          m_arm_prev;
    bit          m_low_seen;
    int          mem [int];
    logic [17:0] e_hi;
    logic [13:0] e_rd;
    bit          e_rd_ok;
    logic [13:0] q_rd;
    bit          q_ok;

    initial begin
        m_phase = 0; m_cnt = 0; m_wp = 0; m_arm_prev = 0; m_low_seen = 0;
        e_hi = '0; e_rd = '0; e_rd_ok = 1; q_rd = '0; q_ok = 0;
    end

    always @(posedge clk) begin : model
        int a;
        bit arm;
        bit rise;
        bit start;
        a   = int'(bif.gpio_ctrl[13:0]);
        arm = bif.gpio_ctrl[14];
        // status register shows the view that held just before this edge
        if (rst) begin
            e_hi = '0; e_rd = '0; e_rd_ok = 1;
        end else begin
            e_hi    = {(m_phase == 1), 15'(m_cnt), (m_phase == 1 || m_phase == 2), (m_phase == 3)};
            e_rd    = q_rd;
            e_rd_ok = q_ok;
        end
        // RAM output register: old contents of the addressed word
        q_ok = mem.exists(a);
        q_rd = q_ok ? 14'(mem[a]) : 14'd0;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_wp = 0; m_arm_prev = 0; m_low_seen = 0;
        end else begin
            if (m_phase == 2 && bif.adc_valid) begin
                mem[m_wp] = int'(bif.adc_data);
                m_wp  = (m_wp + 1) % DEPTH;
                m_cnt = m_cnt + 1;
            end
            rise = arm && !m_arm_prev && m_low_seen;
`ifdef CAPTURE_TRIG_EN
            start = bif.trigger;
`else
            start = 1'b1;
`endif
            if (!arm)                          m_phase = 0;
            else if (m_phase == 0 && rise)     begin m_phase = 1; m_cnt = 0; m_wp = 0; end
            else if (m_phase == 1 && start)    m_phase = 2;
            else if (m_phase == 2 && m_cnt == LEN) m_phase = 3;
            m_arm_prev = arm;
            m_low_seen = m_low_seen || !arm;
        end
    end

    always @(negedge clk) begin : compare
        if (rst) begin
            chk("rst_status", bif.gpio_status, 32'd0);
            chk("rst_active", 32'(bif.capture_active), 32'd0);
        end else begin
            chk("active", 32'(bif.capture_active), 32'(m_phase == 2));
            chk("status_hi", 32'(bif.gpio_status[31:14]), 32'(e_hi));
            if (e_rd_ok) chk("rdata", 32'(bif.gpio_status[13:0]), 32'(e_rd));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ctrl(input bit arm, input int addr);
        logic [16:0] junk;
        junk = 17'($urandom);
        bif.gpio_ctrl = {junk, arm, 14'(addr)};
    endtask

    task automatic read_chk(input string nm, input bit arm, input int addr, input int exp);
        set_ctrl(arm, addr);
        tick(3);
        chk(nm, 32'(bif.gpio_status[13:0]), 32'(exp));
    endtask

    task automatic wait_active(input string nm);
        int n;
        n = 0;
        while (!bif.capture_active && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 32'(bif.capture_active), 32'd1);
    endtask

    task automatic ramp(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bif.adc_valid = 1'b1;
            bif.adc_data  = 14'(base + i);
            tick();
        end
        bif.adc_valid = 1'b0;
    endtask

    task automatic rearm();
        set_ctrl(0, 0);
        tick(2);
        set_ctrl(1, 0);
    endtask

    initial begin : stim
        int k;
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bif.gpio_ctrl = '0;
        bif.adc_data  = '0;
        bif.adc_valid = 1'b0;
        bif.trigger   = 1'b1;
        tick(3);
        chk("reset_status", bif.gpio_status, 32'd0);
        chk("reset_active", 32'(bif.capture_active), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: full ramp capture
        set_ctrl(1, 0);
        wait_active("t1_enter");
        ramp(0, 16);
        tick(2);
        chk("t1_done", 32'(bif.gpio_status[14]), 32'd1);
        chk("t1_busy", 32'(bif.gpio_status[15]), 32'd0);
        chk("t1_count", 32'(bif.gpio_status[30:16]), 32'd16);
        read_chk("t1_rd5", 1, 5, 5);
        read_chk("t1_rd15", 1, 15, 15);
        tick(10);
        chk("t1_hold_done", 32'(bif.gpio_status[14]), 32'd1);
        chk("t1_hold_idle", 32'(bif.capture_active), 32'd0);

        // 2: gapped valid, samples stored contiguously
        rearm();
        wait_active("t2_enter");
        k = 0; n = 0;
        while (bif.capture_active && n < 80) begin
            bif.adc_valid = (n % 2 == 0);
            bif.adc_data  = bif.adc_valid ? 14'(100 + k) : 14'h3abc;
            if (bif.adc_valid) k++;
            tick();
            n++;
        end
        bif.adc_valid = 1'b0;
        tick(2);
        chk("t2_count", 32'(bif.gpio_status[30:16]), 32'd16);
        read_chk("t2_rd3", 1, 3, 103);
        read_chk("t2_rd15", 1, 15, 115);

        // 3: abort after 7 samples
        rearm();
        wait_active("t3_enter");
        ramp(200, 7);
        set_ctrl(0, 0);
        tick(3);
        chk("t3_busy", 32'(bif.gpio_status[15]), 32'd0);
        chk("t3_done", 32'(bif.gpio_status[14]), 32'd0);
        chk("t3_count", 32'(bif.gpio_status[30:16]), 32'd7);
        read_chk("t3_rd0", 0, 0, 200);
        read_chk("t3_rd6", 0, 6, 206);
        read_chk("t3_rd7", 0, 7, 107);

`ifdef CAPTURE_TRIG_EN
        // 4: ARMED waits for trigger
        bif.trigger = 1'b0;
        rearm();
        tick(100);
        chk("t4_armed", 32'(bif.gpio_status[31]), 32'd1);
        chk("t4_count", 32'(bif.gpio_status[30:16]), 32'd0);
        chk("t4_idle", 32'(bif.capture_active), 32'd0);
        bif.trigger = 1'b1;
        tick();
        chk("t4_start", 32'(bif.capture_active), 32'd1);
        ramp(500, 4);
        set_ctrl(0, 0);
        tick(2);
`endif

        // 5: async reset mid-capture, held arm must not restart
        rearm();
        wait_active("t5_enter");
        ramp(600, 5);
        bif.adc_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_status", bif.gpio_status, 32'd0);
        chk("t5_rst_active", 32'(bif.capture_active), 32'd0);
        tick(3);
        bif.adc_valid = 1'b0;
        rst = 1'b0;
        tick(6);
        chk("t5_held_active", 32'(bif.capture_active), 32'd0);
        chk("t5_held_busy", 32'(bif.gpio_status[15]), 32'd0);
        chk("t5_held_armed", 32'(bif.gpio_status[31]), 32'd0);
        read_chk("t5_rd2", 1, 2, 602);

        // 6: re-arm after DONE overwrites from 0
        rearm();
        wait_active("t6a_enter");
        ramp(300, 16);
        tick(2);
        chk("t6a_done", 32'(bif.gpio_status[14]), 32'd1);
        read_chk("t6a_rd0", 1, 0, 300);
        rearm();
        wait_active("t6b_enter");
        tick(2);
        chk("t6b_count0", 32'(bif.gpio_status[30:16]), 32'd0);
        ramp(400, 16);
        tick(2);
        chk("t6b_count", 32'(bif.gpio_status[30:16]), 32'd16);
        read_chk("t6b_rd0", 1, 0, 400);
        read_chk("t6b_rd15", 1, 15, 415);

        // random phase, model-checked every cycle
        begin
            bit arm;
            arm = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) arm = !arm;
                set_ctrl(arm, int'($urandom_range(0, 31)));
                bif.adc_valid = 1'($urandom);
                bif.adc_data  = 14'($urandom);
                bif.trigger   = ($urandom_range(0, 7) == 0);
                if (i == 1500) begin
                    #2 rst = 1'b1;
                    tick(2);
                    rst = 1'b0;
                end else begin
                    tick();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
